// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// The key map matches the printed legend on the keypad.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEB_P,
        PRESSED,
        DEB_R
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } frame_cls_e;

    // Entry {row, col} holds the key legend; element 0 is row 0 / column 0.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage

// File: rtl/keypad_lookup.sv
// Combinational translation of a (row, column) position to its hex key code.
module keypad_lookup
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx_i,
    input  logic [1:0] col_idx_i,
    output logic [3:0] code_o
);

    assign code_o = KEYMAP[{row_idx_i, col_idx_i}];

endmodule

// File: rtl/hex_keypad_scanner.sv
// Column-strobing 4x4 keypad scanner with per-frame debounce, one-cycle key
// events and a shift-in hex entry register for the display.
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 65536,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DATA_W         = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [3:0]        col,
    input  logic [3:0]        row,
    input  logic              clear,
    output logic [3:0]        key_code,
    output logic              key_valid,
    output logic              key_down,
    output logic [DATA_W-1:0] value
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]        row_meta_q, row_sync_q;
    logic [DIV_W-1:0]  div_q;
    logic [1:0]        col_idx_q;
    logic [1:0]        hits_q;
    logic [3:0]        hit_key_q;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cand_q, cand_d;
    logic              key_valid_q;
    logic [3:0]        key_code_q;
    logic [DATA_W-1:0] value_q, value_shift;

    logic              tc, frame_end, accept;
    logic [3:0]        lows;
    logic [2:0]        low_cnt;
    logic [1:0]        row_idx, col_hits;
    logic [2:0]        hits_sum;
    logic [3:0]        pos_code, frame_key;
    logic [CNT_W-1:0]  cnt_inc;
    frame_cls_e        frame_cls;

    assign tc        = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tc && (col_idx_q == 2'(NUM_COLS - 1));
    assign lows      = ~row_sync_q;

    always_comb begin
        low_cnt = '0;
        row_idx = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (lows[r]) begin
                low_cnt = low_cnt + 3'd1;
                row_idx = 2'(r);
            end
        end
    end

    keypad_lookup u_lookup (
        .row_idx_i (row_idx),
        .col_idx_i (col_idx_q),
        .code_o    (pos_code)
    );

    // Pairs seen so far this frame, saturating at 2 since only 0/1/many matters.
    assign col_hits  = (low_cnt == 3'd0) ? 2'd0 : (low_cnt == 3'd1) ? 2'd1 : 2'd2;
    assign hits_sum  = {1'b0, hits_q} + {1'b0, col_hits};
    assign frame_key = (col_hits == 2'd1) ? pos_code : hit_key_q;
    assign frame_cls = (hits_sum == 3'd0) ? CLS_NONE :
                       (hits_sum == 3'd1) ? CLS_SINGLE : CLS_MULTI;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            div_q      <= '0;
            col_idx_q  <= '0;
            hits_q     <= '0;
            hit_key_q  <= '0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            if (tc) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                if (frame_end) begin
                    hits_q    <= '0;
                    hit_key_q <= '0;
                end else begin
                    hits_q <= (hits_sum > 3'd2) ? 2'd2 : hits_sum[1:0];
                    if (col_hits == 2'd1) begin
                        hit_key_q <= pos_code;
                    end
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // FSM state register together with the event outputs it launches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            value_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= cand_d;
            end
            if (clear) begin
                value_q <= '0;
            end else if (accept) begin
                value_q <= value_shift;
            end
        end
    end

    generate
        if (DATA_W > 4) begin : g_shift
            assign value_shift = {value_q[DATA_W-5:0], cand_d};
        end else begin : g_single
            assign value_shift = cand_d;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_cls == CLS_SINGLE) begin
                        cand_d = frame_key;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            state_d = DEB_P;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEB_P: begin
                    if (frame_cls == CLS_SINGLE && frame_key == cand_q) begin
                        if (cnt_inc == DEB_LIMIT) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (frame_cls == CLS_NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = DEB_R;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEB_R: begin
                    if (frame_cls == CLS_NONE) begin
                        if (cnt_inc == DEB_LIMIT) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        col       = ~(4'b0001 << col_idx_q);
        key_down  = (state_q == PRESSED) || (state_q == DEB_R);
        key_valid = key_valid_q;
        key_code  = key_code_q;
        value     = value_q;
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner with a behavioural 4x4 key matrix.
module tb_hex_keypad_scanner;

    localparam int SCAN_DIV       = 8;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int DATA_W         = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        col;
    logic [3:0]        row;
    logic              clear;
    logic [3:0]        key_code;
    logic              key_valid;
    logic              key_down;
    logic [DATA_W-1:0] value;

    logic [15:0]       keys;
    logic [DATA_W-1:0] exp_value;
    int                total = 0;
    int                bad   = 0;

    typedef struct {
        logic [3:0]        code;
        logic [DATA_W-1:0] val;
    } exp_t;
    exp_t sb[$];
    exp_t ev;
    bit   kv_prev = 1'b0;

    hex_keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .DATA_W         (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .clear     (clear),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .value     (value)
    );

    always #5 clk = ~clk;

    // Pressed key at (r, c) pulls row r low while column c is strobed low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (kv_prev) begin
            chk("pulse_width", {31'd0, key_valid}, 32'd0);
        end
        if (key_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_event", {28'd0, key_code}, 32'hFFFF);
            end else begin
                ev = sb.pop_front();
                chk("key_code", {28'd0, key_code}, {28'd0, ev.code});
                chk("value", {20'd0, value}, {20'd0, ev.val});
                $display("event code=%0h value=%03h expected code=%0h value=%03h",
                         key_code, value, ev.code, ev.val);
            end
        end
        kv_prev = key_valid;
    end

    task automatic wait_frame_start();
        logic [3:0] prev;
        prev = col;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (col == 4'b1110 && prev == 4'b0111) begin
                return;
            end
            prev = col;
        end
        chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) begin
            wait_frame_start();
        end
    endtask

    task automatic push_exp(input logic [3:0] code);
        exp_value = {exp_value[DATA_W-5:0], code};
        sb.push_back('{code: code, val: exp_value});
    endtask

    task automatic tap(input int idx, input logic [3:0] code);
        wait_frame_start();
        push_exp(code);
        keys = 16'(1) << idx;
        wait_frames(4);
        chk("down_held", {31'd0, key_down}, 32'd1);
        keys = '0;
        wait_frames(4);
        chk("down_released", {31'd0, key_down}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ce;
        rst_n     = 1'b0;
        clear     = 1'b0;
        keys      = '0;
        exp_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_col", {28'd0, col}, 32'hE);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_down", {31'd0, key_down}, 32'd0);
        chk("rst_value", {20'd0, value}, 32'd0);
        chk("rst_code", {28'd0, key_code}, 32'd0);
        rst_n = 1'b1;

        wait_frame_start();
        for (int i = 0; i < 4; i++) begin
            ce = ~(4'b0001 << i);
            chk("col_scan", {28'd0, col}, {28'd0, ce});
            repeat (SCAN_DIV) @(negedge clk);
        end
        wait_frames(2);
        chk("idle_value", {20'd0, value}, 32'd0);
        chk("idle_down", {31'd0, key_down}, 32'd0);

        tap(6, 4'h6);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_idle", {20'd0, value}, 32'd0);
        exp_value = '0;

        tap(0, 4'h1);
        tap(1, 4'h2);
        tap(2, 4'h3);
        tap(3, 4'hA);
        chk("wrap_value", {20'd0, value}, 32'h23A);

        // Bounce on key 5: two frames down, one up, then a clean press.
        wait_frame_start();
        keys = 16'(1) << 5;
        wait_frames(2);
        keys = '0;
        wait_frames(1);
        push_exp(4'h5);
        keys = 16'(1) << 5;
        wait_frames(4);
        chk("bounce_down", {31'd0, key_down}, 32'd1);
        keys = '0;
        wait_frames(4);

        // Keys 1 and 9 together, then 9 alone with 1 added later.
        keys = 16'h0401;
        wait_frames(5);
        chk("multi_down", {31'd0, key_down}, 32'd0);
        keys = '0;
        wait_frames(1);
        push_exp(4'h9);
        keys = 16'(1) << 10;
        wait_frames(4);
        keys = 16'h0401;
        wait_frames(4);
        chk("multi_held_down", {31'd0, key_down}, 32'd1);
        keys = '0;
        wait_frames(4);
        chk("multi_released", {31'd0, key_down}, 32'd0);

        // Reset while key 7 is in press debounce.
        wait_frame_start();
        keys = 16'(1) << 8;
        wait_frames(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_col", {28'd0, col}, 32'hE);
        chk("mid_rst_value", {20'd0, value}, 32'd0);
        chk("mid_rst_code", {28'd0, key_code}, 32'd0);
        chk("mid_rst_down", {31'd0, key_down}, 32'd0);
        exp_value = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(2);
        push_exp(4'h7);
        wait_frames(2);
        chk("post_rst_down", {31'd0, key_down}, 32'd1);
        keys = '0;
        wait_frames(4);

        // Clear in the very cycle that the press of key C is accepted.
        wait_frame_start();
        sb.push_back('{code: 4'hC, val: '0});
        exp_value = '0;
        keys = 16'(1) << 11;
        wait_frames(2);
        repeat (4 * SCAN_DIV - 1) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_wins_valid", {31'd0, key_valid}, 32'd1);
        chk("clear_wins_value", {20'd0, value}, 32'd0);
        keys = '0;
        wait_frames(4);
        chk("final_down", {31'd0, key_down}, 32'd0);

        repeat (10) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
